// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and the fill pattern for the memory fill/check engine.
package mem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_STROBE = 3'd2,
        S_R_ADDR   = 3'd3,
        S_R_CMP    = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    // (2*k + seed) mod 2**data_w, computed in 32 bits so any width up to 31 works.
    function automatic int unsigned expected(input int unsigned k,
                                             input int unsigned seed,
                                             input int unsigned data_w);
        int unsigned mask;
        mask = (32'd1 << data_w) - 32'd1;
        return (2 * k + seed) & mask;
    endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Combinational pattern source: location index and seed in, expected data byte out.
module mem_pattern_gen
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic [ADDR_W-1:0] k_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = DATA_W'(expected(32'(k_i), 32'(seed_i), DATA_W));

endmodule

// File: rtl/mem_fill_check.sv
// Fill-and-verify engine: writes the seeded pattern to every memory location, reads it
// back, and reports pass/fail, mismatch count and the first failing address.
module mem_fill_check
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] K_LAST = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] fea_q, fea_d;
    logic              pass_q, pass_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d, mem_cs_q, mem_cs_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] wr_exp, cmp_exp;
    logic              mismatch;

    // Same generator on both paths so write and compare data are bit-identical.
    mem_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_gen_wr (
        .k_i(k_d), .seed_i(seed_d), .data_o(wr_exp)
    );
    mem_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_gen_cmp (
        .k_i(k_q), .seed_i(seed_q), .data_o(cmp_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            seed_q  <= seed_d;
        end
    end

    // start is accepted only in IDLE (where it beats abort); abort wins everywhere else.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        seed_d  = seed_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W_SETUP;
                    k_d     = '0;
                    seed_d  = seed;
                end
            end
            S_W_SETUP:  state_d = S_W_STROBE;
            S_W_STROBE: begin
                if (k_q == K_LAST) begin
                    state_d = S_R_ADDR;
                    k_d     = '0;
                end else begin
                    state_d = S_W_SETUP;
                    k_d     = k_q + 1'b1;
                end
            end
            S_R_ADDR:   state_d = S_R_CMP;
            S_R_CMP: begin
                if (k_q == K_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_R_ADDR;
                    k_d     = k_q + 1'b1;
                end
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are registered from the next state, so they line up with the state itself.
    always_comb begin
        mismatch      = (state_q == S_R_CMP) && !abort && (mem_data_out != cmp_exp);
        err_d         = err_q;
        fea_d         = fea_q;
        pass_d        = pass_q;
        if (state_q == S_IDLE && start) begin
            err_d = '0;
            fea_d = '0;
        end
        if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) begin
                fea_d = k_q;
            end
        end
        if (state_d == S_FINISH) begin
            pass_d = (err_d == '0);
        end
        mem_cs_d      = (state_d == S_W_SETUP) || (state_d == S_W_STROBE) ||
                        (state_d == S_R_ADDR)  || (state_d == S_R_CMP);
        mem_wr_d      = (state_d == S_W_STROBE);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_FINISH);
        mem_addr_d    = mem_cs_d ? k_d : mem_addr_q;
        mem_data_in_d = ((state_d == S_W_SETUP) || (state_d == S_W_STROBE)) ? wr_exp
                                                                              : mem_data_in_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q         <= '0;
            fea_q         <= '0;
            pass_q        <= 1'b0;
            mem_data_in_q <= '0;
            mem_addr_q    <= '0;
            mem_wr_q      <= 1'b0;
            mem_cs_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            err_q         <= err_d;
            fea_q         <= fea_d;
            pass_q        <= pass_d;
            mem_data_in_q <= mem_data_in_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_q      <= mem_wr_d;
            mem_cs_q      <= mem_cs_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign mem_data_in    = mem_data_in_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wr         = mem_wr_q;
    assign mem_cs         = mem_cs_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = fea_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_fill_check.sv
// Directed bench for mem_fill_check with a 1024 x 8 memory model and optional stuck-at faults.
module tb_mem_fill_check;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic [7:0]  mem_data_in;
    logic [9:0]  mem_addr;
    logic        mem_wr;
    logic        mem_cs;
    logic [7:0]  mem_data_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;
    state_t      dbg_state;

    logic [7:0]  mem_arr [0:1023];
    logic        fault_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cyc;
    int n_done;

    mem_fill_check dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .mem_data_in(mem_data_in), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_cs(mem_cs),
        .mem_data_out(mem_data_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read, bit 0 stuck-at-1 at 6 and 900.
    always @(posedge clk) begin
        if (mem_cs && mem_wr) mem_arr[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem_arr[mem_addr] |
                          {7'b0, fault_en && (mem_addr == 10'd6 || mem_addr == 10'd900)};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1 (start seen at edge 0).
    task automatic pulse_start(input logic [7:0] s);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Bounded watch of a run; optionally re-pulses start (with a different seed) while busy.
    task automatic wait_done(input int restart_at, output int d_cyc, output int d_cnt);
        d_cyc = 0;
        d_cnt = 0;
        for (int cyc = 1; cyc <= 4200; cyc++) begin
            if (done) begin
                d_cnt++;
                if (d_cyc == 0) d_cyc = cyc;
            end
            if (cyc == restart_at) begin
                start = 1'b1;
                seed  = 8'hff;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_cs", mem_cs, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data_in, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fea", first_err_addr, 0);
        chk("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;
        wait_cycles(2);

        // Clean run, seed 0, with a second start ignored mid-run
        pulse_start(8'h00);
        chk("lat_busy", busy, 1);
        chk("lat_state", dbg_state, S_W_SETUP);
        chk("lat_cs_wr", {mem_cs, mem_wr}, 2'b10);
        wait_done(100, done_cyc, n_done);
        chk("s0_done_cyc", done_cyc, 4097);
        chk("s0_done_cnt", n_done, 1);
        chk("s0_busy_end", busy, 0);
        chk("s0_pass", pass, 1);
        chk("s0_err", err_count, 0);
        chk("s0_fea", first_err_addr, 0);
        chk("s0_loc5", mem_arr[5], 10);
        chk("s0_loc200", mem_arr[200], 144);
        chk("s0_loc1023", mem_arr[1023], 254);

        // Seed 3
        pulse_start(8'h03);
        wait_done(0, done_cyc, n_done);
        chk("s3_done_cyc", done_cyc, 4097);
        chk("s3_loc0", mem_arr[0], 3);
        chk("s3_loc127", mem_arr[127], 1);
        chk("s3_loc1023", mem_arr[1023], 1);
        chk("s3_pass", pass, 1);

        // Stuck-at faults at 6 and 900
        fault_en = 1'b1;
        pulse_start(8'h00);
        wait_done(0, done_cyc, n_done);
        chk("flt_done_cyc", done_cyc, 4097);
        chk("flt_err", err_count, 2);
        chk("flt_fea", first_err_addr, 6);
        chk("flt_pass", pass, 0);

        // Abort during R_CMP at k=300 (cycle 2650); faults still on so k=6 is counted
        pulse_start(8'h00);
        wait_cycles(2649);
        chk("ab_state", dbg_state, S_R_CMP);
        chk("ab_addr", mem_addr, 300);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_cs", mem_cs, 0);
        chk("ab_wr", mem_wr, 0);
        chk("ab_busy", busy, 0);
        chk("ab_state_idle", dbg_state, S_IDLE);
        chk("ab_pass_held", pass, 0);
        chk("ab_err_held", err_count, 1);
        chk("ab_fea_held", first_err_addr, 6);
        wait_done(0, done_cyc, n_done);
        chk("ab_no_done", n_done, 0);
        fault_en = 1'b0;

        // Asynchronous reset during W_STROBE at k=10 (cycle 22)
        pulse_start(8'h00);
        wait_cycles(21);
        chk("rs_state", dbg_state, S_W_STROBE);
        chk("rs_addr", mem_addr, 10);
        chk("rs_wr", mem_wr, 1);
        chk("rs_data", mem_data_in, 20);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_wr0", mem_wr, 0);
        chk("rs_cs0", mem_cs, 0);
        chk("rs_addr0", mem_addr, 0);
        chk("rs_data0", mem_data_in, 0);
        chk("rs_err0", err_count, 0);
        chk("rs_fea0", first_err_addr, 0);
        chk("rs_state0", dbg_state, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(8'h00);
        wait_done(0, done_cyc, n_done);
        chk("rs_run_done_cyc", done_cyc, 4097);
        chk("rs_run_pass", pass, 1);
        chk("rs_run_err", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
